// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the PC, issues word fetches over a valid/ready
// channel, pairs in-order responses with their PC and buffers them for decode.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      fifo_q [DEPTH];
  logic [31:0] tag_q  [DEPTH];

  logic [31:0]      pc_q,      pc_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [CNT_W-1:0] out_q,     out_d;
  logic [CNT_W-1:0] drop_q,    drop_d;
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [PTR_W-1:0] tag_wr_q,  tag_wr_d;
  logic [PTR_W-1:0] tag_rd_q,  tag_rd_d;

  logic [SUM_W-1:0] budget;
  logic             req_fire;
  logic             rsp_ok;
  logic             push;
  logic             pop;
  entry_t           head;

  // Every buffered or in-flight fetch holds a slot, so a push never finds the FIFO full.
  assign budget         = SUM_W'(count_q) + SUM_W'(out_q);
  assign imem_req_valid = rst && !PCSrcE && (budget < SUM_W'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing in flight are a protocol error and are ignored.
  assign rsp_ok = imem_rsp_valid && (out_q != '0);
  assign push   = rsp_ok && (drop_q == '0) && !PCSrcE;
  assign pop    = ValidD && !StallD && !PCSrcE;

  assign head     = fifo_q[rd_ptr_q];
  assign ValidD   = (count_q != '0);
  assign InstrD   = ValidD ? head.instr : 32'h0;
  assign PCD      = ValidD ? head.pc : 32'h0;
  assign PCPlus4D = ValidD ? (head.pc + 32'd4) : 32'h0;

  // Next-state logic; a redirect overrides every other FIFO and PC update.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    out_d    = out_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);
    drop_d   = drop_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    tag_wr_d = tag_wr_q + PTR_W'(req_fire);
    tag_rd_d = tag_rd_q + PTR_W'(rsp_ok);

    if (PCSrcE) begin
      pc_d     = PCTargetE;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // Everything still in flight after this edge belongs to the old path.
      drop_d   = out_q - CNT_W'(rsp_ok);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_ok && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[tag_wr_q] <= pc_q;
    end
    if (push) begin
      fifo_q[wr_ptr_q] <= '{instr: imem_rsp_data, pc: tag_q[tag_rd_q]};
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order, variable-latency
// instruction memory model driven from the bench.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .StallD         (StallD),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .ValidD         (ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          cyc;
  int          lat;
  int          n_chk;
  int          n_err;

  logic        o_v;
  logic        o_rv;
  logic [31:0] o_ra;
  logic [31:0] o_pc;
  logic [31:0] o_p4;
  logic [31:0] o_ins;
  logic        acc;
  logic        rsp_seen;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_rsp();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  // Observe the current cycle midway between active edges.
  task automatic sample();
    @(negedge clk);
    o_v      = ValidD;
    o_rv     = imem_req_valid;
    o_ra     = imem_req_addr;
    o_pc     = PCD;
    o_p4     = PCPlus4D;
    o_ins    = InstrD;
    acc      = imem_req_valid && imem_req_ready;
    rsp_seen = imem_rsp_valid;
  endtask

  // Cross the active edge and update the memory model with what it saw.
  task automatic advance();
    mreq_t r;
    @(posedge clk);
    #1;
    if (rsp_seen && mem_q.size() > 0) void'(mem_q.pop_front());
    if (acc) begin
      r.addr = o_ra;
      r.due  = cyc + lat;
      mem_q.push_back(r);
    end
    cyc++;
    drive_rsp();
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; lat = 1;
    rst = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    acc = 1'b0; rsp_seen = 1'b0;

    repeat (2) @(posedge clk);
    sample();
    chk("rst_validd", 32'(o_v), 32'd0);
    chk("rst_req_valid", 32'(o_rv), 32'd0);
    chk("rst_pcd", o_pc, 32'h0);
    chk("rst_pcplus4d", o_p4, 32'h0);
    chk("rst_instrd", o_ins, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 0;

    // Stream at latency 1
    sample();
    chk("c0_req_valid", 32'(o_rv), 32'd1);
    chk("c0_addr", o_ra, 32'h0);
    chk("c0_validd", 32'(o_v), 32'd0);
    advance();
    sample();
    chk("c1_addr", o_ra, 32'h4);
    chk("c1_validd", 32'(o_v), 32'd0);
    advance();
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("stream_validd", 32'(o_v), 32'd1);
      chk("stream_pcd", o_pc, 32'(4 * k));
      chk("stream_pcplus4d", o_p4, 32'(4 * k + 4));
      chk("stream_instrd", o_ins, instr_of(32'(4 * k)));
      advance();
    end

    // Decode stall fills the FIFO, then drains in order
    StallD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("stall_validd", 32'(o_v), 32'd1);
      chk("stall_pcd", o_pc, 32'h10);
      chk("stall_req_valid", 32'(o_rv), (k >= 2) ? 32'd0 : 32'd1);
      chk("stall_addr", o_ra, (k >= 2) ? 32'h20 : 32'(24 + 4 * k));
      advance();
    end
    StallD = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("drain_validd", 32'(o_v), 32'd1);
      chk("drain_pcd", o_pc, 32'(16 + 4 * k));
      chk("drain_req_valid", 32'(o_rv), (k == 0) ? 32'd0 : 32'd1);
      chk("drain_addr", o_ra, (k <= 1) ? 32'h20 : 32'(32 + 4 * (k - 1)));
      advance();
    end

    // Memory not ready: address holds while the FIFO empties
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("nrdy_addr", o_ra, 32'h34);
      chk("nrdy_req_valid", 32'(o_rv), 32'd1);
      chk("nrdy_pcd", o_pc, 32'(40 + 4 * k));
      advance();
    end
    imem_req_ready = 1'b1;
    sample();
    chk("nrdy_empty_validd", 32'(o_v), 32'd0);
    chk("nrdy_resume_addr", o_ra, 32'h34);
    advance();
    sample();
    chk("nrdy_empty2_validd", 32'(o_v), 32'd0);
    chk("nrdy_next_addr", o_ra, 32'h38);
    advance();
    sample();
    chk("nrdy_refill_pcd", o_pc, 32'h34);
    chk("nrdy_refill_instrd", o_ins, instr_of(32'h34));
    advance();

    // Build count=3 with nothing in flight, then reset asynchronously
    StallD = 1'b1;
    sample();
    advance();
    imem_req_ready = 1'b0;
    sample();
    advance();
    sample();
    chk("pre_rst_validd", 32'(o_v), 32'd1);
    chk("pre_rst_pcd", o_pc, 32'h38);
    chk("pre_rst_req_valid", 32'(o_rv), 32'd1);
    chk("pre_rst_addr", o_ra, 32'h44);
    #2;
    rst = 1'b0;
    mem_q.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    #1;
    chk("async_rst_validd", 32'(ValidD), 32'd0);
    chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_rst_pcd", PCD, 32'h0);
    chk("async_rst_instrd", InstrD, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_req_ready = 1'b1; StallD = 1'b0; lat = 1;
    rst = 1'b1; cyc = 0;

    // Redirect with three requests in flight at latency 4
    sample();
    chk("restart_req_valid", 32'(o_rv), 32'd1);
    chk("restart_addr", o_ra, 32'h0);
    advance();
    lat = 4;
    sample();
    advance();
    StallD = 1'b1;
    sample();
    chk("rd_pre_pcd", o_pc, 32'h0);
    advance();
    sample();
    chk("rd_pre_addr", o_ra, 32'hC);
    advance();
    StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100;
    sample();
    chk("rd_cycle_validd", 32'(o_v), 32'd1);
    chk("rd_cycle_req_valid", 32'(o_rv), 32'd0);
    advance();
    PCSrcE = 1'b0; lat = 1;
    sample();
    chk("rd_flush_validd", 32'(o_v), 32'd0);
    chk("rd_target_req_valid", 32'(o_rv), 32'd1);
    chk("rd_target_addr", o_ra, 32'h100);
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("rd_drop_validd", 32'(o_v), 32'd0);
      advance();
    end
    sample();
    chk("rd_first_validd", 32'(o_v), 32'd1);
    chk("rd_first_pcd", o_pc, 32'h100);
    chk("rd_first_pcplus4d", o_p4, 32'h104);
    chk("rd_first_instrd", o_ins, instr_of(32'h100));
    advance();
    sample();
    chk("rd_second_pcd", o_pc, 32'h104);
    advance();

    // Redirect coinciding with a response and a decode pop
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    sample();
    chk("rdx_cycle_pcd", o_pc, 32'h108);
    chk("rdx_cycle_req_valid", 32'(o_rv), 32'd0);
    advance();
    PCSrcE = 1'b0;
    sample();
    chk("rdx_flush_validd", 32'(o_v), 32'd0);
    chk("rdx_target_addr", o_ra, 32'h100);
    advance();
    sample();
    chk("rdx_drop_validd", 32'(o_v), 32'd0);
    advance();
    sample();
    chk("rdx_first_validd", 32'(o_v), 32'd1);
    chk("rdx_first_pcd", o_pc, 32'h100);
    chk("rdx_first_instrd", o_ins, instr_of(32'h100));
    advance();
    sample();
    chk("rdx_second_pcd", o_pc, 32'h104);
    advance();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
